m_trap_ctrl: RTL and testbench

// Machine-mode trap sequencer for the RV32 core. Detects synchronous exceptions and

---
 rtl/m_trap_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_m_trap_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/m_trap_ctrl.sv
// Machine-mode trap sequencer: prioritises exceptions/interrupts at retirement,
// drives mepc/mcause/mtval write strobes, redirects fetch and sequences MRET.
module m_trap_ctrl #(
    parameter logic [11:0] MSTATUS  = 12'h300,
    parameter logic [11:0] MIE_ADDR = 12'h304
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        instr_valid_in,
    input  logic [31:0] pc_in,
    input  logic        instr_misalign_in,
    input  logic        illegal_in,
    input  logic [31:0] instr_in,
    input  logic        ebreak_in,
    input  logic        ecall_in,
    input  logic        ld_misalign_in,
    input  logic        st_misalign_in,
    input  logic [31:0] mem_addr_in,
    input  logic        mret_in,
    input  logic        msip_in,
    input  logic        mtip_in,
    input  logic        meip_in,
    input  logic [11:0] csr_addr_in,
    input  logic        csr_wr_en_in,
    input  logic [31:0] csr_data_in,
    input  logic [31:0] trap_address_in,
    input  logic [31:0] mepc_in,
    output logic [3:0]  cause_out,
    output logic        int_or_exc_out,
    output logic        mepc_we_out,
    output logic        mcause_we_out,
    output logic        mtval_we_out,
    output logic [31:0] epc_out,
    output logic [31:0] mtval_out,
    output logic        stall_out,
    output logic        flush_out,
    output logic        redirect_out,
    output logic [31:0] redirect_pc_out,
    output logic        mstatus_mie_out,
    output logic        mstatus_mpie_out,
    output logic [31:0] mie_out
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_VECTOR  = 2'd2;
    localparam logic [1:0] S_RESTORE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cause_q, cause_d;
    logic        int_q, int_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] trap_addr_q, trap_addr_d;
    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic        msie_q, msie_d;
    logic        mtie_q, mtie_d;
    logic        meie_q, meie_d;

    logic        in_idle;
    logic        exc_any;
    logic [3:0]  exc_cause;
    logic [31:0] exc_tval;
    logic        irq_any;
    logic [3:0]  irq_cause;
    logic        trap_take;
    logic        mret_take;
    logic [3:0]  trap_cause;

    // Synchronous exceptions, highest priority first.
    always_comb begin
        exc_any   = 1'b1;
        exc_cause = 4'd0;
        exc_tval  = '0;
        if (instr_misalign_in) begin
            exc_cause = 4'd0;
        end else if (illegal_in) begin
            exc_cause = 4'd2;
            exc_tval  = instr_in;
        end else if (ebreak_in) begin
            exc_cause = 4'd3;
        end else if (ecall_in) begin
            exc_cause = 4'd11;
        end else if (ld_misalign_in) begin
            exc_cause = 4'd4;
            exc_tval  = mem_addr_in;
        end else if (st_misalign_in) begin
            exc_cause = 4'd6;
            exc_tval  = mem_addr_in;
        end else begin
            exc_any = 1'b0;
        end
    end

    always_comb begin
        irq_any   = 1'b1;
        irq_cause = 4'd0;
        if (meip_in && meie_q) begin
            irq_cause = 4'd11;
        end else if (msip_in && msie_q) begin
            irq_cause = 4'd3;
        end else if (mtip_in && mtie_q) begin
            irq_cause = 4'd7;
        end else begin
            irq_any = 1'b0;
        end
    end

    assign in_idle    = (state_q == S_IDLE);
    assign trap_take  = in_idle && instr_valid_in && (exc_any || (irq_any && mie_q));
    assign mret_take  = in_idle && instr_valid_in && mret_in && !trap_take;
    assign trap_cause = exc_any ? exc_cause : irq_cause;

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        int_d       = int_q;
        epc_d       = epc_q;
        mtval_d     = mtval_q;
        trap_addr_d = trap_addr_q;
        mie_d       = mie_q;
        mpie_d      = mpie_q;
        msie_d      = msie_q;
        mtie_d      = mtie_q;
        meie_d      = meie_q;
        case (state_q)
            S_IDLE: begin
                if (trap_take) begin
                    state_d     = S_CAPTURE;
                    cause_d     = trap_cause;
                    int_d       = !exc_any;
                    epc_d       = pc_in;
                    mtval_d     = exc_any ? exc_tval : '0;
                    trap_addr_d = trap_address_in;
                end else if (mret_take) begin
                    state_d = S_RESTORE;
                end else if (csr_wr_en_in) begin
                    // CSR write only lands when no trap/MRET claims this cycle.
                    if (csr_addr_in == MSTATUS) begin
                        mie_d  = csr_data_in[3];
                        mpie_d = csr_data_in[7];
                    end else if (csr_addr_in == MIE_ADDR) begin
                        msie_d = csr_data_in[3];
                        mtie_d = csr_data_in[7];
                        meie_d = csr_data_in[11];
                    end
                end
            end
            S_CAPTURE: begin
                state_d = S_VECTOR;
                mpie_d  = mie_q;
                mie_d   = 1'b0;
            end
            S_VECTOR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                mie_d   = mpie_q;
                mpie_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            cause_q     <= '0;
            int_q       <= 1'b0;
            epc_q       <= '0;
            mtval_q     <= '0;
            trap_addr_q <= '0;
            mie_q       <= 1'b0;
            mpie_q      <= 1'b0;
            msie_q      <= 1'b0;
            mtie_q      <= 1'b0;
            meie_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            int_q       <= int_d;
            epc_q       <= epc_d;
            mtval_q     <= mtval_d;
            trap_addr_q <= trap_addr_d;
            mie_q       <= mie_d;
            mpie_q      <= mpie_d;
            msie_q      <= msie_d;
            mtie_q      <= mtie_d;
            meie_q      <= meie_d;
        end
    end

    // Cause is live in the trap cycle itself, then held from the latch.
    assign cause_out      = in_idle ? (trap_take ? trap_cause : 4'd0) : cause_q;
    assign int_or_exc_out = in_idle ? (trap_take && !exc_any) : int_q;

    assign mepc_we_out    = (state_q == S_CAPTURE);
    assign mcause_we_out  = (state_q == S_CAPTURE);
    assign mtval_we_out   = (state_q == S_CAPTURE);
    assign epc_out        = epc_q;
    assign mtval_out      = mtval_q;

    assign stall_out       = trap_take || mret_take || !in_idle;
    assign redirect_out    = (state_q == S_VECTOR) || (state_q == S_RESTORE);
    assign flush_out       = redirect_out;
    assign redirect_pc_out = (state_q == S_VECTOR)  ? trap_addr_q :
                             (state_q == S_RESTORE) ? mepc_in : '0;

    assign mstatus_mie_out  = mie_q;
    assign mstatus_mpie_out = mpie_q;
    assign mie_out          = {20'd0, meie_q, 3'd0, mtie_q, 3'd0, msie_q, 3'd0};

endmodule

// File: tb/tb_m_trap_ctrl.sv
// Directed bench for m_trap_ctrl with a small mtvec model driving trap_address_in.
module tb_m_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [31:0] pc = '0;
    logic        imis = 1'b0, ill = 1'b0, ebrk = 1'b0, ecl = 1'b0, ldm = 1'b0, stm = 1'b0;
    logic [31:0] instr = '0, maddr = '0;
    logic        mret = 1'b0, msip = 1'b0, mtip = 1'b0, meip = 1'b0;
    logic [11:0] caddr = '0;
    logic        cwe = 1'b0;
    logic [31:0] cdata = '0;
    logic [31:0] mepc = '0;

    logic [31:0] mtvec_base = 32'h200;
    logic        mtvec_vec  = 1'b0;
    logic [31:0] trap_addr;

    logic [3:0]  cause;
    logic        int_exc, mepc_we, mcause_we, mtval_we, stall, flush, redir, st_mie, st_mpie;
    logic [31:0] epc, mtval, redir_pc, mie_reg;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    // mtvec: vectored mode offsets interrupts only.
    assign trap_addr = (mtvec_vec && int_exc) ? mtvec_base + {26'd0, cause, 2'b00} : mtvec_base;

    m_trap_ctrl #(.MSTATUS(12'h300), .MIE_ADDR(12'h304)) dut (
        .clk_in(clk), .rst_in(rst), .instr_valid_in(valid), .pc_in(pc),
        .instr_misalign_in(imis), .illegal_in(ill), .instr_in(instr),
        .ebreak_in(ebrk), .ecall_in(ecl), .ld_misalign_in(ldm), .st_misalign_in(stm),
        .mem_addr_in(maddr), .mret_in(mret), .msip_in(msip), .mtip_in(mtip), .meip_in(meip),
        .csr_addr_in(caddr), .csr_wr_en_in(cwe), .csr_data_in(cdata),
        .trap_address_in(trap_addr), .mepc_in(mepc),
        .cause_out(cause), .int_or_exc_out(int_exc),
        .mepc_we_out(mepc_we), .mcause_we_out(mcause_we), .mtval_we_out(mtval_we),
        .epc_out(epc), .mtval_out(mtval), .stall_out(stall), .flush_out(flush),
        .redirect_out(redir), .redirect_pc_out(redir_pc),
        .mstatus_mie_out(st_mie), .mstatus_mpie_out(st_mpie), .mie_out(mie_reg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exc(input logic [5:0] f);
        {imis, ill, ebrk, ecl, ldm, stm} = f;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        caddr = a; cdata = d; cwe = 1'b1;
        tick();
        cwe = 1'b0;
    endtask

    // Full trap: T -> CAPTURE -> VECTOR -> IDLE; mtvec is disturbed after T to
    // confirm the latched target is used.
    task automatic trap_seq(input string tag, input logic [5:0] f, input logic [31:0] tpc,
                            input logic [3:0] ecause, input logic eint,
                            input logic [31:0] etval, input logic [31:0] etgt);
        logic [31:0] saved_base;
        valid = 1'b1; pc = tpc; set_exc(f);
        #1;
        check({tag, ".cause"}, {28'd0, cause}, {28'd0, ecause});
        check({tag, ".int"}, {31'd0, int_exc}, {31'd0, eint});
        check({tag, ".stall_T"}, {31'd0, stall}, 32'd1);
        tick();
        valid = 1'b0; set_exc(6'b0);
        saved_base = mtvec_base;
        mtvec_base = 32'hFFF0_0000;
        #1;
        check({tag, ".we"}, {29'd0, mepc_we, mcause_we, mtval_we}, 32'd7);
        check({tag, ".epc"}, epc, tpc);
        check({tag, ".mtval"}, mtval, etval);
        check({tag, ".cause_hold"}, {27'd0, int_exc, cause}, {27'd0, eint, ecause});
        check({tag, ".redir_cap"}, {31'd0, redir}, 32'd0);
        tick();
        check({tag, ".vec_ctl"}, {28'd0, redir, flush, stall, mepc_we}, 32'b1110);
        check({tag, ".vec_pc"}, redir_pc, etgt);
        tick();
        mtvec_base = saved_base;
        check({tag, ".idle"}, {30'd0, redir, stall}, 32'd0);
    endtask

    initial begin
        tick(); tick();
        check("rst.ctl", {26'd0, mepc_we, mcause_we, mtval_we, stall, flush, redir}, 32'd0);
        check("rst.cause", {27'd0, int_exc, cause}, 32'd0);
        check("rst.epc", epc | mtval, 32'd0);
        check("rst.status", {30'd0, st_mie, st_mpie}, 32'd0);
        check("rst.mie", mie_reg, 32'd0);
        rst = 1'b0;
        tick();

        // ECALL, direct mtvec 0x200
        trap_seq("ecall", 6'b000100, 32'h100, 4'd11, 1'b0, 32'd0, 32'h200);
        // Exception priority table
        instr = 32'hDEAD_BEEF; maddr = 32'h0000_1003;
        trap_seq("imis_ecall", 6'b100100, 32'h104, 4'd0, 1'b0, 32'd0, 32'h200);
        trap_seq("ebrk_st", 6'b001001, 32'h108, 4'd3, 1'b0, 32'd0, 32'h200);
        trap_seq("ld_st", 6'b000011, 32'h10C, 4'd4, 1'b0, 32'h1003, 32'h200);
        trap_seq("st", 6'b000001, 32'h110, 4'd6, 1'b0, 32'h1003, 32'h200);
        trap_seq("ill_ld", 6'b010010, 32'h114, 4'd2, 1'b0, 32'hDEAD_BEEF, 32'h200);

        // Timer interrupt, vectored mtvec 0x201
        csr_write(12'h304, 32'h80);
        csr_write(12'h300, 32'h8);
        check("csr.mie", mie_reg, 32'h80);
        check("csr.mstatus", {30'd0, st_mie, st_mpie}, 32'b10);
        mtvec_vec = 1'b1; mtip = 1'b1;
        trap_seq("mti", 6'b0, 32'h140, 4'd7, 1'b1, 32'd0, 32'h21C);
        check("mti.status", {30'd0, st_mie, st_mpie}, 32'b01);
        valid = 1'b1; pc = 32'h144;
        #1;
        check("mti.masked", {31'd0, stall}, 32'd0);
        tick();
        valid = 1'b0; mtip = 1'b0;

        // Illegal beats a pending external interrupt
        csr_write(12'h304, 32'h880);
        csr_write(12'h300, 32'h88);
        meip = 1'b1; instr = 32'h1234_5678;
        trap_seq("ill_mei", 6'b010000, 32'h180, 4'd2, 1'b0, 32'h1234_5678, 32'h200);
        valid = 1'b1; pc = 32'h184;
        #1;
        check("mei.waits", {31'd0, stall}, 32'd0);
        tick();
        valid = 1'b0; meip = 1'b0;

        // MRET with MPIE=1
        check("mret.pre", {30'd0, st_mie, st_mpie}, 32'b01);
        mepc = 32'h104; valid = 1'b1; mret = 1'b1;
        #1;
        check("mret.T", {30'd0, stall, redir}, 32'b10);
        tick();
        valid = 1'b0; mret = 1'b0;
        check("mret.restore", {30'd0, redir, flush}, 32'b11);
        check("mret.pc", redir_pc, 32'h104);
        tick();
        check("mret.status", {30'd0, st_mie, st_mpie}, 32'b11);
        check("mret.idle", {31'd0, redir}, 32'd0);

        // CSR write to mstatus dropped when a trap fires that cycle
        mtvec_vec = 1'b0;
        csr_write(12'h300, 32'h0);
        caddr = 12'h300; cdata = 32'h8; cwe = 1'b1;
        trap_seq("ecall_csr", 6'b000100, 32'h1C0, 4'd11, 1'b0, 32'd0, 32'h200);
        cwe = 1'b0;
        check("ecall_csr.mie", {31'd0, st_mie}, 32'd0);

        // Reset during CAPTURE
        valid = 1'b1; ecl = 1'b1; pc = 32'h200;
        tick();
        valid = 1'b0; ecl = 1'b0;
        check("rstmid.cap", {31'd0, mepc_we}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstmid.ctl", {26'd0, mepc_we, mcause_we, mtval_we, stall, flush, redir}, 32'd0);
        check("rstmid.cause", {27'd0, int_exc, cause}, 32'd0);
        check("rstmid.epc", epc, 32'd0);
        #1 rst = 1'b0;
        tick();
        check("rstmid.next", {29'd0, redir, stall, mepc_we}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
